// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson counter phase decoder.
// The optional jump check is enabled with JOHNSON_PHASE_SEQ_CHECK_EN.
package johnson_pkg;

    localparam int PHASES = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Legal codes, written as {q0,q1,q2,q3}
    localparam logic [3:0] CODE_0 = 4'b0000;
    localparam logic [3:0] CODE_1 = 4'b1000;
    localparam logic [3:0] CODE_2 = 4'b1100;
    localparam logic [3:0] CODE_3 = 4'b1110;
    localparam logic [3:0] CODE_4 = 4'b1111;
    localparam logic [3:0] CODE_5 = 4'b0111;
    localparam logic [3:0] CODE_6 = 4'b0011;
    localparam logic [3:0] CODE_7 = 4'b0001;

    function automatic logic [PHASES-1:0] idx_onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [PHASES-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational map from a 4-bit Johnson code to its phase index.
// Codes outside the 8-state rotation report legal_o = 0.
module johnson_code_decode
    import johnson_pkg::*;
(
    input  logic [3:0]       code_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             legal_o
);

    always_comb begin
        idx_o   = '0;
        legal_o = 1'b1;
        case (code_i)
            CODE_0:  idx_o = 3'd0;
            CODE_1:  idx_o = 3'd1;
            CODE_2:  idx_o = 3'd2;
            CODE_3:  idx_o = 3'd3;
            CODE_4:  idx_o = 3'd4;
            CODE_5:  idx_o = 3'd5;
            CODE_6:  idx_o = 3'd6;
            CODE_7:  idx_o = 3'd7;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Tracks a 4-bit Johnson counter: registered one-hot phase, rotation count, faults.
// Define JOHNSON_PHASE_SEQ_CHECK_EN to fault on legal but out-of-sequence codes.
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int CYCLE_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               q0,
    input  logic               q1,
    input  logic               q2,
    input  logic               q3,
    input  logic               err_clr,
    output logic [PHASES-1:0]  phase,
    output logic [IDX_W-1:0]   phase_idx,
    output logic               valid,
    output logic               wrap,
    output logic [CYCLE_W-1:0] cycle_cnt,
    output logic               fault,
    output logic [3:0]         fault_code
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PHASES-1:0]  phase_q, phase_d;
    logic               wrap_q, wrap_d;
    logic [CYCLE_W-1:0] cnt_q, cnt_d;
    logic [3:0]         fcode_q, fcode_d;

    logic [3:0]         code;
    logic [IDX_W-1:0]   dec_idx;
    logic               dec_legal;
    logic [IDX_W-1:0]   succ_idx;

    assign code     = {q0, q1, q2, q3};
    assign succ_idx = idx_q + IDX_W'(1);

    johnson_code_decode u_decode (
        .code_i  (code),
        .idx_o   (dec_idx),
        .legal_o (dec_legal)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        fcode_d = fcode_q;
        unique case (state_q)
            SYNC: begin
                if (dec_legal) begin
                    state_d = LOCK;
                    idx_d   = dec_idx;
                end else begin
                    state_d = FAULT;
                    fcode_d = code;
                end
            end
            LOCK: begin
                if (!dec_legal) begin
                    state_d = FAULT;
                    fcode_d = code;
                end else if (dec_idx == idx_q) begin
                    // stalled counter: hold the current phase
                    idx_d = idx_q;
                end else if (dec_idx == succ_idx) begin
                    idx_d = dec_idx;
                    if (idx_q == IDX_W'(PHASES - 1)) begin
                        wrap_d = 1'b1;
                        cnt_d  = cnt_q + CYCLE_W'(1);
                    end
                end else begin
`ifdef JOHNSON_PHASE_SEQ_CHECK_EN
                    state_d = FAULT;
                    fcode_d = code;
`else
                    idx_d = dec_idx;
`endif
                end
            end
            FAULT: begin
                if (err_clr) begin
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
        phase_d = (state_d == LOCK) ? idx_onehot(idx_d) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SYNC;
            idx_q   <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            fcode_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            fcode_q <= fcode_d;
        end
    end

    assign phase      = phase_q;
    assign phase_idx  = idx_q;
    assign valid      = (state_q == LOCK);
    assign wrap       = wrap_q;
    assign cycle_cnt  = cnt_q;
    assign fault      = (state_q == FAULT);
    assign fault_code = fcode_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder; a second instance runs with CYCLE_W=2.
// Jump expectations follow JOHNSON_PHASE_SEQ_CHECK_EN.
module tb_johnson_phase_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       q0, q1, q2, q3;
    logic       err_clr;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       valid, wrap, fault;
    logic [7:0] cycle_cnt;
    logic [3:0] fault_code;

    logic [7:0] phase2;
    logic [2:0] phase_idx2;
    logic       valid2, wrap2, fault2;
    logic [1:0] cycle_cnt2;
    logic [3:0] fault_code2;

    int tests = 0;
    int fails = 0;

    logic [3:0] codes [8];
    logic [7:0] exp_cnt;

    always #5 clock = ~clock;

    johnson_phase_decoder #(.CYCLE_W(8)) u_dut (
        .clock(clock), .reset(reset),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .err_clr(err_clr),
        .phase(phase), .phase_idx(phase_idx),
        .valid(valid), .wrap(wrap),
        .cycle_cnt(cycle_cnt),
        .fault(fault), .fault_code(fault_code)
    );

    johnson_phase_decoder #(.CYCLE_W(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .err_clr(err_clr),
        .phase(phase2), .phase_idx(phase_idx2),
        .valid(valid2), .wrap(wrap2),
        .cycle_cnt(cycle_cnt2),
        .fault(fault2), .fault_code(fault_code2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] c);
        {q0, q1, q2, q3} = c;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_lock(input string tag, input int idx,
                            input logic w, input logic [7:0] cnt);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".idx"}, 32'(phase_idx), 32'(idx));
        chk({tag, ".phase"}, 32'(phase), 32'(8'd1 << idx));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
        chk({tag, ".cnt"}, 32'(cycle_cnt), 32'(cnt));
        chk({tag, ".fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        codes[0] = 4'b0000; codes[1] = 4'b1000;
        codes[2] = 4'b1100; codes[3] = 4'b1110;
        codes[4] = 4'b1111; codes[5] = 4'b0111;
        codes[6] = 4'b0011; codes[7] = 4'b0001;
        reset = 1'b1;
        err_clr = 1'b0;
        step(4'b0000);
        step(4'b0000);
        chk("rst.phase", 32'(phase), 32'd0);
        chk("rst.idx", 32'(phase_idx), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.wrap", 32'(wrap), 32'd0);
        chk("rst.cnt", 32'(cycle_cnt), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.fcode", 32'(fault_code), 32'd0);
        reset = 1'b0;

        // three free-running rotations
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                step(codes[i]);
                chk_lock("rot", i, (r > 0 && i == 0), 8'(r));
            end
        end
        chk("rot.cnt2", 32'(cycle_cnt2), 32'd2);

        // wrap into idx 0, then stall at 1110
        step(4'b0000);
        chk_lock("wrap3", 0, 1'b1, 8'd3);
        step(4'b1000);
        chk("post_wrap", 32'(wrap), 32'd0);
        step(4'b1100);
        for (int k = 0; k < 5; k++) begin
            step(4'b1110);
            chk_lock("hold", 3, 1'b0, 8'd3);
        end

        // illegal code while locked; err_clr in LOCK does not block entry
        err_clr = 1'b1;
        step(4'b1010);
        err_clr = 1'b0;
        chk("ill.fault", 32'(fault), 32'd1);
        chk("ill.fcode", 32'(fault_code), 32'hA);
        chk("ill.valid", 32'(valid), 32'd0);
        chk("ill.phase", 32'(phase), 32'd0);
        step(4'b0000);
        chk("ill.stay", 32'(fault), 32'd1);
        chk("ill.fcode2", 32'(fault_code), 32'hA);
        err_clr = 1'b1;
        step(4'b1010);
        err_clr = 1'b0;
        chk("clr.fault", 32'(fault), 32'd0);
        chk("clr.valid", 32'(valid), 32'd0);
        step(4'b1111);
        chk_lock("relock", 4, 1'b0, 8'd3);

        // advance to idx 2, then jump to idx 4
        step(4'b0111);
        step(4'b0011);
        step(4'b0001);
        step(4'b0000);
        chk_lock("wrap4", 0, 1'b1, 8'd4);
        chk("wrap4.cnt2", 32'(cycle_cnt2), 32'd0);
        step(4'b1000);
        step(4'b1100);
        step(4'b1111);
`ifdef JOHNSON_PHASE_SEQ_CHECK_EN
        chk("jump.fault", 32'(fault), 32'd1);
        chk("jump.fcode", 32'(fault_code), 32'hF);
        chk("jump.phase", 32'(phase), 32'd0);
        err_clr = 1'b1;
        step(4'b1111);
        err_clr = 1'b0;
        step(4'b1111);
        chk_lock("jump.relock", 4, 1'b0, 8'd4);
`else
        chk_lock("jump", 4, 1'b0, 8'd4);
`endif

        // reset at idx 5
        step(4'b0111);
        chk_lock("pre_rst", 5, 1'b0, 8'd4);
        reset = 1'b1;
        step(4'b0111);
        chk("mrst.phase", 32'(phase), 32'd0);
        chk("mrst.idx", 32'(phase_idx), 32'd0);
        chk("mrst.valid", 32'(valid), 32'd0);
        chk("mrst.cnt", 32'(cycle_cnt), 32'd0);
        chk("mrst.fault", 32'(fault), 32'd0);
        reset = 1'b0;
        step(4'b0111);
        chk_lock("mrst.relock", 5, 1'b0, 8'd0);
        step(4'b0011);
        step(4'b0001);

        // four rotations: narrow counter reads 1,2,3,0
        exp_cnt = 8'd0;
        for (int r = 1; r <= 4; r++) begin
            exp_cnt = exp_cnt + 8'd1;
            step(4'b0000);
            chk_lock("w2", 0, 1'b1, exp_cnt);
            chk("w2.cnt2", 32'(cycle_cnt2), 32'(r % 4));
            chk("w2.wrap2", 32'(wrap2), 32'd1);
            for (int i = 1; i < 8; i++) begin
                step(codes[i]);
            end
        end
        chk_lock("end", 7, 1'b0, 8'd4);

        // illegal code straight out of SYNC
        err_clr = 1'b0;
        reset = 1'b1;
        step(4'b0101);
        reset = 1'b0;
        step(4'b0101);
        chk("sync_ill.fault", 32'(fault), 32'd1);
        chk("sync_ill.fcode", 32'(fault_code), 32'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the 4-bit Johnson counter. It samples the counter's four outputs every clock and decodes the 8-state Johnson code into a registered one-hot phase and a phase index. It counts completed rotations and detects illegal codes and out-of-sequence jumps. Its phase outputs drive the sequencing logic that follows the counter.

## Interface
- `CYCLE_W`, default 8: width of the rotation counter `cycle_cnt`.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `q0`, in, 1: counter stage output; the stage that receives the inverted feedback.
- `q1`, in, 1: counter stage output.
- `q2`, in, 1: counter stage output.
- `q3`, in, 1: counter stage output; the feedback source.
- `err_clr`, in, 1: clears the FAULT state; level-sampled.
- `phase`, out, 8: registered one-hot phase; all zeros when not locked.
- `phase_idx`, out, 3: registered phase index 0..7.
- `valid`, out, 1: high while in LOCK.
- `wrap`, out, 1: one-cycle pulse on the 7→0 transition.
- `cycle_cnt`, out, `CYCLE_W`: number of completed rotations, modulo 2^`CYCLE_W`.
- `fault`, out, 1: high while in FAULT.
- `fault_code`, out, 4: the {q0,q1,q2,q3} value that caused the fault.

## Operation
- Code map, written as {q0,q1,q2,q3} → idx: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
- All other 8 codes are illegal.
- FSM states: SYNC, LOCK, FAULT.
- SYNC (reset state):
  - Legal code → LOCK; load `phase_idx`.
  - Illegal code → FAULT.
- LOCK:
  - Legal code with next idx = prev idx: hold. This tolerates a stalled counter.
  - Legal code with next idx = (prev+1) mod 8: advance.
  - Any other legal idx is a sequence jump → FAULT. This check exists only with the macro defined (see Configuration).
  - Illegal code → FAULT.
- FAULT:
  - `fault_code` is latched on entry.
  - The block stays in FAULT until `err_clr`=1, then goes to SYNC.
  - `err_clr` is ignored outside FAULT.
- `wrap` and `cycle_cnt`:
  - Both act only on the LOCK→LOCK transition from idx 7 to idx 0.
  - `cycle_cnt` increments and wraps from 2^`CYCLE_W`−1 to 0.
  - Entering LOCK from SYNC at idx 0 is not a wrap.
- `phase` = 1<<`phase_idx` while in LOCK, else 0.

## Timing
- One-cycle latency: a code present at rising edge N appears on `phase`, `phase_idx` and `valid` after edge N.
- Values after reset: `phase`=0, `phase_idx`=0, `valid`=0, `wrap`=0, `cycle_cnt`=0, `fault`=0, `fault_code`=0, state=SYNC.
- Reset has priority over everything.
- Reset asserted mid-rotation discards the count and the lock. Tracking resumes from SYNC on the first cycle after reset deasserts.
- `wrap` is high for exactly the cycle in which `phase_idx` shows 0 after 7.
- A fault and `err_clr` in the same cycle:
  - While in LOCK: FAULT entry wins.
  - While in FAULT: the block leaves to SYNC. A bad code in that cycle is ignored and is re-evaluated from SYNC on the next cycle.
- `cycle_cnt` holds its value through FAULT and SYNC. Only `reset` clears it.

## Configuration
- Macro: `JOHNSON_PHASE_SEQ_CHECK_EN`.
- Defined: the LOCK jump check is active, so a legal but non-successor code → FAULT.
- Undefined:
  - The jump check logic is absent.
  - Any legal code is accepted in LOCK and the block relocks to it without error.
  - `wrap` fires only on an exact 7→0 step.

## Structure
- Package `johnson_pkg` holds:
  - the FSM state enum (SYNC, LOCK, FAULT);
  - the 8 legal-code constants;
  - the phase count constant (8) and index width (3).
- Sub-module `johnson_code_decode`, combinational: {q0,q1,q2,q3} → idx[2:0], legal. It is instantiated once.

## Test plan
- Free-running sequence 0000,1000,1100,1110,1111,0111,0011,0001, repeated 3 times:
  - `valid` rises 1 cycle after the first code;
  - `phase` walks 0x01…0x80;
  - `wrap` pulses 2 times;
  - `cycle_cnt`=2.
- Illegal code 1010 injected in LOCK → `fault`=1, `fault_code`=1010, `valid`=0, `phase`=0. `err_clr` pulse → SYNC. The next legal code → LOCK.
- Jump 1100→1111 (idx 2→4):
  - With the macro: FAULT, `fault_code`=1111.
  - Without it: `phase_idx`=4, no fault, no wrap.
- Held code 1110 for 5 cycles → `phase_idx` stays 3, no fault, `cycle_cnt` unchanged.
- With `CYCLE_W`=2, run 4 full rotations → `cycle_cnt` goes 1,2,3,0.
- `reset` asserted at idx 5 after 3 rotations → the next cycle shows all outputs 0 and state SYNC. After release, relock occurs at the current code with `cycle_cnt`=0.
